// File: rtl/bundler_acc.sv
// bundler_acc: streaming majority bundler for hypervectors.
//
// Accepts a set of hypervectors one per cycle and keeps a per-dimension
// population count. When the set ends, either on in_last or because MAX_HVS
// vectors have arrived, it thresholds the counts PAR_BITS dimensions per
// cycle into a majority hypervector. That result is then held until the
// consumer takes it.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready only in ACCUM, low in reset)
//   hv_in, in_last      input hypervector and end-of-set marker
//   tie_mode            tie policy, latched on the first accept of a set:
//                       0 = zero, 1 = one, 2 = first HV bit, 3 = zero
//   out_valid, out_ready  output handshake
//   hv_out              bundled hypervector
//   out_count           number of HVs in the set
//   out_trunc           set was closed by MAX_HVS rather than in_last
module bundler_acc #(
    parameter int unsigned DIMENSIONS = 10000,
    parameter int unsigned MAX_HVS    = 64,
    parameter int unsigned PAR_BITS   = 100,
    localparam int unsigned CNT_W     = $clog2(MAX_HVS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIMENSIONS-1:0] hv_in,
    input  logic                  in_last,
    input  logic [1:0]            tie_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMENSIONS-1:0] hv_out,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_trunc
);

    localparam int unsigned NumChunks = (DIMENSIONS + PAR_BITS - 1) / PAR_BITS;
    localparam int unsigned IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam int unsigned DimW      = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

    typedef enum logic [1:0] {StAccum, StThresh, StOut} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q [DIMENSIONS];
    logic [CNT_W-1:0]        cnt_d [DIMENSIONS];
    logic [CNT_W-1:0]        n_q, n_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DIMENSIONS-1:0]   tb_q, tb_d;
    logic [1:0]              tie_mode_q, tie_mode_d;
    logic                    trunc_q, trunc_d;
    logic [DIMENSIONS-1:0]   hv_out_q, hv_out_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_trunc_q, out_trunc_d;

    logic                    accept;

    assign in_ready  = (state_q == StAccum) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == StOut);
    assign hv_out    = hv_out_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

    always_comb begin
        int unsigned      dim;
        logic [DimW-1:0]  sel;
        logic [CNT_W:0]   twice_cnt;
        logic [CNT_W:0]   n_ext;
        logic             bit_val;

        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        idx_d       = idx_q;
        tb_d        = tb_q;
        tie_mode_d  = tie_mode_q;
        trunc_d     = trunc_q;
        hv_out_d    = hv_out_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;
        dim         = 0;
        sel         = '0;
        twice_cnt   = '0;
        n_ext       = '0;
        bit_val     = 1'b0;

        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    for (int unsigned d = 0; d < DIMENSIONS; d++) begin
                        cnt_d[d] = cnt_q[d] + CNT_W'(hv_in[d]);
                    end
                    n_d = n_q + CNT_W'(1);
                    if (n_q == '0) begin
                        tb_d       = hv_in;
                        tie_mode_d = tie_mode;
                    end
                    // Compare before the increment so the MAX_HVS-th vector closes the set.
                    if (in_last || (n_q == CNT_W'(MAX_HVS - 1))) begin
                        state_d = StThresh;
                        idx_d   = '0;
                        trunc_d = !in_last;
                    end
                end
            end

            StThresh: begin
                for (int unsigned j = 0; j < PAR_BITS; j++) begin
                    dim = 32'(idx_q) * PAR_BITS + j;
                    // The last chunk may run past the vector; those lanes are dropped.
                    if (dim < DIMENSIONS) begin
                        sel       = DimW'(dim);
                        twice_cnt = {cnt_q[sel], 1'b0};
                        n_ext     = {1'b0, n_q};
                        if (twice_cnt > n_ext) begin
                            bit_val = 1'b1;
                        end else if (twice_cnt < n_ext) begin
                            bit_val = 1'b0;
                        end else begin
                            case (tie_mode_q)
                                2'd1:    bit_val = 1'b1;
                                2'd2:    bit_val = tb_q[sel];
                                default: bit_val = 1'b0;
                            endcase
                        end
                        hv_out_d[sel] = bit_val;
                    end
                end
                if (idx_q == IdxW'(NumChunks - 1)) begin
                    state_d     = StOut;
                    out_count_d = n_q;
                    out_trunc_d = trunc_q;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end

            StOut: begin
                if (out_ready) begin
                    for (int unsigned d = 0; d < DIMENSIONS; d++) begin
                        cnt_d[d] = '0;
                    end
                    n_d     = '0;
                    idx_d   = '0;
                    state_d = StAccum;
                end
            end

            default: begin
                state_d = StAccum;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAccum;
            for (int unsigned d = 0; d < DIMENSIONS; d++) begin
                cnt_q[d] <= '0;
            end
            n_q         <= '0;
            idx_q       <= '0;
            tb_q        <= '0;
            tie_mode_q  <= '0;
            trunc_q     <= 1'b0;
            hv_out_q    <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            tb_q        <= tb_d;
            tie_mode_q  <= tie_mode_d;
            trunc_q     <= trunc_d;
            hv_out_q    <= hv_out_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

endmodule
